audio_i2s_rx: RTL and testbench
===============================

Name: audio_i2s_rx

Overview:
- Deserializes the WM8731 ADC serial stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT) into parallel left/right sample pairs in the Clk domain.
- The codec is bus master; this block is slave-only and oversamples the codec clocks with Clk (50 MHz).
- Sits directly upstream of the audio effect path and audio system core, and hands off stereo pairs through a valid/ready interface.
- Reports overflow and framing errors for the LED/HEX debug display.

Parameters:
- DATA_WIDTH, 16, bits per channel word, MSB first.
- I2S_MODE, 1, 1 = I2S format (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on the first BCLK after LRCK edge).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- AUD_BCLK  input  1  codec bit clock, asynchronous to Clk.
- AUD_ADCLRCK  input  1  codec ADC frame clock; low = left, high = right.
- AUD_ADCDAT  input  1  codec ADC serial data.
- sample_l  output  DATA_WIDTH  left sample, two's complement.
- sample_r  output  DATA_WIDTH  right sample, two's complement.
- out_valid  output  1  pair available.
- out_ready  input  1  consumer accepts the pair when out_valid && out_ready.
- clear_overflow  input  1  clears overflow.
- overflow  output  1  sticky; a pair was overwritten before acceptance.
- frame_err_count  output  8  saturating count of short words.

Behaviour:
- Synchronization:
  - 2-flop synchronizers on BCLK, ADCLRCK and ADCDAT.
  - A BCLK rise event (bclk_rise) is the cycle where the synchronized BCLK is 1 and its previous value is 0.
  - All serial sampling happens only in bclk_rise cycles, using the synchronized LRCK/DAT.
  - lr_prev holds LRCK as sampled at the previous bclk_rise. A channel edge is LRCK != lr_prev at a bclk_rise.
- States:
  - IDLE: wait for a channel edge with LRCK = 0 (start of left). Then go to SKIP if I2S_MODE, else go to SHIFT with the current DAT captured as MSB (bit count = 1). Other edges are ignored.
  - SKIP: at the next bclk_rise, capture DAT as MSB, bit count = 1, go to SHIFT.
  - SHIFT: at each bclk_rise, shift DAT in at the LSB and increment the count. When the count reaches DATA_WIDTH:
    - Store the word into the left holding register (channel 0) or the right holding register (channel 1).
    - Go to WAIT.
  - WAIT: ignore bits until a channel edge, then re-enter SKIP/SHIFT as from IDLE for the new channel. Channel = LRCK.
- Frame error: a channel edge in SHIFT before DATA_WIDTH bits are collected.
  - Discard the partial word and increment frame_err_count, saturating at 8'hFF.
  - Realign to the new channel (SKIP/SHIFT as above).
  - If the new channel is right and no left word is held for the current frame, go to IDLE.
- Pair completion:
  - Completion is the right word stored while a left word is held for the same frame.
  - On the next Clk: sample_l/sample_r take the held words and out_valid = 1.
  - Latency from the AUD_BCLK pin rise carrying the right LSB to out_valid high is 4 Clk cycles (2 sync + edge detect + register).
- Handshake:
  - out_valid stays 1 until accepted. Data stays stable while out_valid && !out_ready.
  - Acceptance clears out_valid on the next Clk unless a new pair completes in the same cycle. In that case the new pair is loaded, out_valid stays 1, and overflow is not set.
  - A completion while out_valid && !out_ready overwrites the pair, keeps out_valid = 1, and sets overflow.
- overflow clear: clear_overflow clears overflow. If a set and a clear occur in the same cycle, set wins.
- Reset:
  - Reset values: sample_l = 0, sample_r = 0, out_valid = 0, overflow = 0, frame_err_count = 0, state = IDLE. Synchronizers, lr_prev and holding registers are also cleared.
  - Reset mid-word discards all partial data; capture resumes only at the next left-channel edge.
- BCLK must be at most Clk/4. Faster BCLK is unsupported and undefined.

Test Plan:
- I2S_MODE=1, BCLK = Clk/16, left 16'hA5C3, right 16'h0F0F → sample_l = A5C3, sample_r = 0F0F, out_valid high 4 Clk after the right LSB rise; out_ready=1 → out_valid low next cycle.
- I2S_MODE=0, same frame, MSB aligned to the LRCK edge → identical outputs. Feeding I2S timing into LJ mode yields the words shifted right by 1 bit.
- out_ready=0 across two frames (1111/2222 then 3333/4444) → outputs 3333/4444, overflow = 1; then clear_overflow pulse → overflow = 0. Simultaneous set and clear → overflow stays 1.
- LRCK toggles after 10 bits of left → frame_err_count = 1, no pair output for that frame; next clean frame outputs correctly. Forcing 300 errors → count = 255.
- Reset asserted mid-right word, released; first post-reset edge is right → no output until a full left+right frame, then correct pair.
- out_ready=1 in the exact cycle a new pair completes → new pair presented, out_valid continuously high, overflow = 0.

Source files
------------

// File: rtl/audio_i2s_rx.sv
// Slave-only I2S / left-justified receiver for the WM8731 ADC stream, oversampled by Clk.
// Produces left/right sample pairs on a valid/ready port with overflow and framing-error status.
module audio_i2s_rx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          I2S_MODE   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clear_overflow,
  output logic                  overflow,
  output logic [7:0]            frame_err_count
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSkip, StShift, StWait} state_e;

  state_e                state_q;
  logic [1:0]            bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                  bclk_prev_q;
  logic                  lr_prev_q;
  logic                  chan_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] left_hold_q, right_hold_q;
  logic                  left_held_q;
  logic                  pair_done_q;

  logic                  bclk_rise, lrck, dat, chan_edge, do_start, frame_err;
  logic [DATA_WIDTH-1:0] word_next;

  always_comb begin
    bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
    lrck      = lrck_sync_q[1];
    dat       = dat_sync_q[1];
    chan_edge = lrck != lr_prev_q;
    word_next = {shift_q[DATA_WIDTH-2:0], dat};
    frame_err = bclk_rise && chan_edge && (state_q == StShift);
    // A right-channel edge only starts capture when its left partner is already held.
    do_start  = bclk_rise && chan_edge && (state_q != StSkip) && (!lrck || left_held_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[0], AUD_ADCDAT};
      bclk_prev_q <= bclk_sync_q[1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= StIdle;
      lr_prev_q       <= 1'b0;
      chan_q          <= 1'b0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      left_hold_q     <= '0;
      right_hold_q    <= '0;
      left_held_q     <= 1'b0;
      pair_done_q     <= 1'b0;
      frame_err_count <= '0;
    end else begin
      pair_done_q <= 1'b0;
      if (frame_err && frame_err_count != 8'hFF) begin
        frame_err_count <= frame_err_count + 8'd1;
      end
      if (bclk_rise) begin
        lr_prev_q <= lrck;
      end
      if (do_start) begin
        chan_q <= lrck;
        if (!lrck) begin
          left_held_q <= 1'b0;
        end
        if (I2S_MODE) begin
          state_q <= StSkip;
        end else begin
          shift_q   <= {{(DATA_WIDTH-1){1'b0}}, dat};
          bit_cnt_q <= CntW'(1);
          state_q   <= StShift;
        end
      end else if (bclk_rise) begin
        unique case (state_q)
          StIdle: ;
          StSkip: begin
            shift_q   <= {{(DATA_WIDTH-1){1'b0}}, dat};
            bit_cnt_q <= CntW'(1);
            state_q   <= StShift;
          end
          StShift: begin
            if (chan_edge) begin
              state_q <= StIdle;
            end else begin
              shift_q   <= word_next;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LastCnt) begin
                state_q <= StWait;
                if (!chan_q) begin
                  left_hold_q <= word_next;
                  left_held_q <= 1'b1;
                end else begin
                  right_hold_q <= word_next;
                  if (left_held_q) begin
                    pair_done_q <= 1'b1;
                    left_held_q <= 1'b0;
                  end
                end
              end
            end
          end
          StWait: begin
            if (chan_edge) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Output pair register and handshake; a completion takes priority over acceptance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_l  <= '0;
      sample_r  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (pair_done_q) begin
        sample_l  <= left_hold_q;
        sample_r  <= right_hold_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (pair_done_q && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: one I2S-mode and one left-justified instance,
// each with its own serial stimulus, expected-pair queue and monitor.
module tb_audio_i2s_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk [2];
  logic        lrck [2];
  logic        dat  [2];
  logic        ready [2];
  logic        clr   [2];
  logic [15:0] sl   [2];
  logic [15:0] sr   [2];
  logic        ov   [2];
  logic        ovf  [2];
  logic [7:0]  fec  [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_done [2];
  event        done_ev;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_i2s_rx #(.DATA_WIDTH(16), .I2S_MODE(1'b1)) dut (
    .Clk(clk), .Reset(rst), .AUD_BCLK(bclk[0]), .AUD_ADCLRCK(lrck[0]), .AUD_ADCDAT(dat[0]),
    .sample_l(sl[0]), .sample_r(sr[0]), .out_valid(ov[0]), .out_ready(ready[0]),
    .clear_overflow(clr[0]), .overflow(ovf[0]), .frame_err_count(fec[0])
  );

  audio_i2s_rx #(.DATA_WIDTH(16), .I2S_MODE(1'b0)) dut_lj (
    .Clk(clk), .Reset(rst), .AUD_BCLK(bclk[1]), .AUD_ADCLRCK(lrck[1]), .AUD_ADCDAT(dat[1]),
    .sample_l(sl[1]), .sample_r(sr[1]), .out_valid(ov[1]), .out_ready(ready[1]),
    .clear_overflow(clr[1]), .overflow(ovf[1]), .frame_err_count(fec[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int s, input logic [15:0] l, input logic [15:0] r);
    if (s == 0) exp_q0.push_back({l, r});
    else        exp_q1.push_back({l, r});
  endtask

  // One channel of `slots` BCLK periods (8 Clk low, 8 Clk high); data changes on BCLK fall.
  // With I2S timing slot 0 is the dead bit. The 16th bit each instance captures is recorded
  // so the monitor can time out_valid against it.
  task automatic send_channel(input int s, input bit lr, input logic [15:0] w, input bit i2s,
                              input int nbits, input int slots);
    int idx;
    for (int k = 0; k < slots; k++) begin
      @(negedge clk);
      bclk[s] = 1'b0;
      lrck[s] = lr;
      idx = k - (i2s ? 1 : 0);
      dat[s] = (idx >= 0 && idx < nbits) ? w[15-idx] : 1'b0;
      repeat (8) @(negedge clk);
      bclk[s] = 1'b1;
      if (lr && k == (s == 0 ? 16 : 15)) begin
        t_done[s] = cyc;
        -> done_ev;
      end
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int s, input logic [15:0] l, input logic [15:0] r,
                            input bit i2s);
    send_channel(s, 1'b0, l, i2s, 16, 18);
    send_channel(s, 1'b1, r, i2s, 16, 18);
  endtask

  // Pops on every handshake (sampled just after the negedge, so it reflects the next posedge).
  task automatic monitor(input int s);
    logic        vprev = 1'b0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && ov[s] && !vprev) chk($sformatf("latency%0d", s), cyc - t_done[s], 4);
      if (!rst && ov[s] && ready[s]) begin
        if ((s == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          chk($sformatf("unexpected_pair%0d", s), {sl[s], sr[s]}, 32'hxxxx_xxxx);
        end else begin
          e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("pair%0d", s), {sl[s], sr[s]}, e);
        end
      end
      vprev = ov[s];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      bclk[s] = 1'b0; lrck[s] = 1'b1; dat[s] = 1'b0; ready[s] = 1'b1; clr[s] = 1'b0;
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", ov[0], 0);
    chk("rst_err", fec[0], 0);

    // Basic I2S frame, then out_valid must have dropped after acceptance.
    send_channel(0, 1'b1, 16'h0, 1'b1, 0, 3);
    push_exp(0, 16'hA5C3, 16'h0F0F);
    send_frame(0, 16'hA5C3, 16'h0F0F, 1'b1);
    chk("valid_dropped", ov[0], 0);

    // Two frames with no consumer: second overwrites first and flags overflow.
    ready[0] = 1'b0;
    send_frame(0, 16'h1111, 16'h2222, 1'b1);
    send_frame(0, 16'h3333, 16'h4444, 1'b1);
    chk("ovf_set", ovf[0], 1);
    chk("valid_held", ov[0], 1);
    push_exp(0, 16'h3333, 16'h4444);
    ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovf_cleared", ovf[0], 0);

    // Overflow set coincident with clear: set wins.
    ready[0] = 1'b0;
    send_frame(0, 16'h5555, 16'h6666, 1'b1);
    fork
      send_frame(0, 16'h7777, 16'h8888, 1'b1);
      begin
        @(done_ev);
        repeat (3) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
      end
    join
    chk("ovf_set_wins", ovf[0], 1);
    push_exp(0, 16'h7777, 16'h8888);
    ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovf_cleared2", ovf[0], 0);

    // Acceptance in the exact completion cycle: new pair loaded, no overflow.
    ready[0] = 1'b0;
    push_exp(0, 16'h9999, 16'hAAAA);
    send_frame(0, 16'h9999, 16'hAAAA, 1'b1);
    push_exp(0, 16'hBBBB, 16'hCCCC);
    fork
      send_frame(0, 16'hBBBB, 16'hCCCC, 1'b1);
      begin
        @(done_ev);
        repeat (3) @(negedge clk);
        ready[0] = 1'b1;
        @(negedge clk);
        #2;
        chk("coinc_valid", ov[0], 1);
        chk("coinc_left", sl[0], 16'hBBBB);
        chk("coinc_ovf", ovf[0], 0);
      end
    join

    // Short left word: one framing error, no pair, then a clean frame.
    send_channel(0, 1'b0, 16'hFFFF, 1'b1, 10, 11);
    send_channel(0, 1'b1, 16'h1357, 1'b1, 16, 18);
    chk("err_one", fec[0], 1);
    push_exp(0, 16'h2468, 16'hACE1);
    send_frame(0, 16'h2468, 16'hACE1, 1'b1);

    // Drive the error counter to one below and then past saturation.
    for (int i = 0; i < 253; i++) begin
      send_channel(0, 1'b0, 16'hF0F0, 1'b1, 3, 4);
      send_channel(0, 1'b1, 16'h0, 1'b1, 0, 2);
    end
    chk("err_254", fec[0], 254);
    for (int i = 0; i < 46; i++) begin
      send_channel(0, 1'b0, 16'hF0F0, 1'b1, 3, 4);
      send_channel(0, 1'b1, 16'h0, 1'b1, 0, 2);
    end
    chk("err_sat", fec[0], 255);

    // Reset in the middle of a right word; first post-reset edge is a right edge.
    send_channel(0, 1'b0, 16'h1234, 1'b1, 16, 18);
    send_channel(0, 1'b1, 16'h5678, 1'b1, 16, 9);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_sl", sl[0], 0);
    chk("rst_sr", sr[0], 0);
    chk("rst_err2", fec[0], 0);
    chk("rst_valid2", ov[0], 0);
    send_channel(0, 1'b1, 16'h5678, 1'b0, 0, 9);
    chk("no_pair_after_rst", ov[0], 0);
    push_exp(0, 16'hCAFE, 16'hBEEF);
    send_frame(0, 16'hCAFE, 16'hBEEF, 1'b1);

    // Left-justified instance: aligned frame, then I2S-timed frame (shifted right by one).
    send_channel(1, 1'b1, 16'h0, 1'b0, 0, 3);
    push_exp(1, 16'hA5C3, 16'h0F0F);
    send_frame(1, 16'hA5C3, 16'h0F0F, 1'b0);
    push_exp(1, 16'h52E1, 16'h0787);
    send_frame(1, 16'hA5C3, 16'h0F0F, 1'b1);

    repeat (20) @(negedge clk);
    chk("queue0_empty", exp_q0.size(), 0);
    chk("queue1_empty", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
